// File: rtl/nco_pkg.sv
// nco_pkg: shared mode encoding and quarter-sine table helpers for the NCO
package nco_pkg;

   typedef enum logic [1:0] {
      MODE_SINE   = 2'd0,
      MODE_SQUARE = 2'd1,
      MODE_SAW    = 2'd2,
      MODE_TRI    = 2'd3
   } mode_e;

   localparam real PI = 3.14159265358979323846;

   function automatic int full_scale(input int out_w);
      return (1 << (out_w - 1)) - 1;
   endfunction

   // Entry k of a 2^lut_aw quarter-wave table, rounded to nearest.
   function automatic int sine_entry(input int k, input int lut_aw, input int out_w);
      return $rtoi(real'(full_scale(out_w)) * $sin(PI * real'(k) / real'(2 ** (lut_aw + 1))) + 0.5);
   endfunction

endpackage

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: registered quarter-sine magnitude table (pipeline stage S2)
//   clk, rst : clock, synchronous active-high reset
//   addr     : quarter-table index
//   full     : select full scale instead of the table (index 2^LUT_AW)
//   mag      : registered unsigned magnitude
module nco_quarter_lut
   import nco_pkg::*;
#(
   parameter int LUT_AW = 6,
   parameter int OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LUT_AW-1:0] addr,
   input  logic              full,
   output logic [OUT_W-1:0]  mag
);

   localparam logic [OUT_W-1:0] FS = OUT_W'(full_scale(OUT_W));

   logic [OUT_W-1:0] rom [2**LUT_AW];

   for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
      assign rom[i] = OUT_W'(sine_entry(i, LUT_AW, OUT_W));
   end

   always_ff @(posedge clk) begin
      if (rst) mag <= '0;
      else     mag <= full ? FS : rom[addr];
   end

endmodule

// File: rtl/nco_wave.sv
// nco_wave: phase-accumulator NCO with sine/square/saw/triangle output
//   clk, rst   : clock, synchronous active-high reset
//   en         : advance the accumulator
//   ctrl       : frequency word, captured on ctrl_load
//   offset     : phase offset added before waveform generation
//   mode       : 0 sine, 1 square, 2 saw, 3 triangle
//   phase_clr  : zero the accumulator and apply any pending word
//   phase/wrap : accumulator value and carry pulse
//   wave_out   : signed sample, 3 cycles after phase; out_valid is en delayed 3
module nco_wave
   import nco_pkg::*;
#(
   parameter int PHASE_W     = 32,
   parameter int OUT_W       = 16,
   parameter int LUT_AW      = 6,
   parameter bit SYNC_UPDATE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [PHASE_W-1:0]      ctrl,
   input  logic                    ctrl_load,
   input  logic [PHASE_W-1:0]      offset,
   input  logic [1:0]              mode,
   input  logic                    phase_clr,
   output logic [PHASE_W-1:0]      phase,
   output logic                    wrap,
   output logic signed [OUT_W-1:0] wave_out,
   output logic                    out_valid
);

   localparam int PW1 = OUT_W + 1;
   localparam logic [OUT_W-1:0] FS = OUT_W'(full_scale(OUT_W));

   logic [PHASE_W-1:0] ctrl_active, pending;
   logic               pend_flag;
   logic [PHASE_W:0]   sum;
   logic               carry, apply;

   assign sum   = {1'b0, phase} + {1'b0, ctrl_active};
   assign carry = en & ~phase_clr & sum[PHASE_W];
   // A word loaded this cycle only becomes visible to apply next cycle.
   assign apply = pend_flag & (phase_clr | carry | !SYNC_UPDATE);

   always_ff @(posedge clk) begin
      if (rst) begin
         phase       <= '0;
         wrap        <= 1'b0;
         ctrl_active <= '0;
         pending     <= '0;
         pend_flag   <= 1'b0;
      end else begin
         phase     <= phase_clr ? '0 : en ? sum[PHASE_W-1:0] : phase;
         wrap      <= carry;
         pend_flag <= ctrl_load | (pend_flag & ~apply);
         if (apply) ctrl_active <= pending;
         if (ctrl_load) pending <= ctrl;
      end
   end

   // S1 keeps only the top OUT_W+1 bits of phase+offset; every waveform uses no more.
   logic [PW1-1:0] p1;
   mode_e          m1;
   logic           v1;

   always_ff @(posedge clk) begin
      if (rst) begin
         p1 <= '0;
         m1 <= MODE_SINE;
         v1 <= 1'b0;
      end else begin
         p1 <= PW1'((phase + offset) >> (PHASE_W - PW1));
         m1 <= mode_e'(mode);
         v1 <= en;
      end
   end

   logic [1:0]        quad;
   logic [LUT_AW-1:0] idx, addr;
   logic              full;
   logic [OUT_W-1:0]  tu, tv, w;

   assign quad = p1[PW1-1 -: 2];
   assign idx  = p1[PW1-3 -: LUT_AW];
   assign addr = quad[0] ? -idx : idx;
   // Odd quadrants at idx 0 would address 2^LUT_AW, one past the table.
   assign full = quad[0] & (idx == '0);
   assign tu   = p1[OUT_W-1:0];
   assign tv   = p1[PW1-1] ? ~tu : tu;

   always_comb begin
      w = (m1 == MODE_SQUARE) ? (p1[PW1-1] ? -FS : FS) :
          (m1 == MODE_SAW)    ? p1[PW1-1:1] :
                                {~tv[OUT_W-1], tv[OUT_W-2:0]};
   end

   logic [OUT_W-1:0] mag2, w2;
   mode_e            m2;
   logic             neg2, v2;

   nco_quarter_lut #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_lut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .full (full),
      .mag  (mag2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         w2        <= '0;
         m2        <= MODE_SINE;
         neg2      <= 1'b0;
         v2        <= 1'b0;
         wave_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         w2        <= w;
         m2        <= m1;
         neg2      <= quad[1];
         v2        <= v1;
         wave_out  <= (m2 == MODE_SINE) ? (neg2 ? -mag2 : mag2) : w2;
         out_valid <= v2;
      end
   end

endmodule

// File: tb/tb_nco_wave.sv
// tb_nco_wave: directed vector and sequence bench for nco_wave
module tb_nco_wave;
   import nco_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, en = 1'b0, ctrl_load = 1'b0, phase_clr = 1'b0;
   logic [31:0] ctrl = '0, offset = '0;
   logic [1:0]  mode = 2'd0;
   logic [31:0] ph0, ph1;
   logic        wr0, wr1, ov0, ov1;
   logic [15:0] wv0, wv1;
   int          tests = 0, fails = 0;
   logic        early_wrap;

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] offset;
      logic [31:0] ph;
      logic [15:0] exp;
   } vec_t;

   vec_t        vecs [$];
   logic [31:0] seq_ph [5] = '{32'h80000000, 32'hC0000000, 32'h00000000, 32'h20000000, 32'h40000000};
   logic        seq_wr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   always #5 clk = ~clk;

   nco_wave #(.SYNC_UPDATE(1'b0)) u0 (
      .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .ctrl_load(ctrl_load),
      .offset(offset), .mode(mode), .phase_clr(phase_clr),
      .phase(ph0), .wrap(wr0), .wave_out(wv0), .out_valid(ov0)
   );

   nco_wave #(.SYNC_UPDATE(1'b1)) u1 (
      .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .ctrl_load(ctrl_load),
      .offset(offset), .mode(mode), .phase_clr(phase_clr),
      .phase(ph1), .wrap(wr1), .wave_out(wv1), .out_valid(ov1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] m, input logic [31:0] o, input logic [31:0] p, input logic [15:0] e);
      vec_t v;
      v.mode = m; v.offset = o; v.ph = p; v.exp = e;
      vecs.push_back(v);
   endtask

   // Reset, then load x into u0 (applies one cycle later) and advance once.
   task automatic set_phase(input logic [31:0] x);
      rst = 1'b1; tick(); rst = 1'b0;
      ctrl = x; ctrl_load = 1'b1; tick(); ctrl_load = 1'b0;
      tick();
      en = 1'b1; tick(); en = 1'b0;
   endtask

   initial begin
      add(MODE_SINE,   32'h00000000, 32'h01000000, 16'h0324);
      add(MODE_SINE,   32'h00000000, 32'h40000000, 16'h7FFF);
      add(MODE_SINE,   32'h00000000, 32'hC0000000, 16'h8001);
      add(MODE_SINE,   32'h00000000, 32'h00000000, 16'h0000);
      add(MODE_SINE,   32'h00000000, 32'h80000000, 16'h0000);
      add(MODE_SINE,   32'h00000000, 32'h41000000, 16'h7FF5);
      add(MODE_SINE,   32'h00000000, 32'hC1000000, 16'h800B);
      add(MODE_SINE,   32'h00000000, 32'h81000000, 16'hFCDC);
      add(MODE_SINE,   32'h40000000, 32'h00000000, 16'h7FFF);
      add(MODE_SINE,   32'hC0000000, 32'h41000000, 16'h0324);
      add(MODE_SQUARE, 32'h80000000, 32'h00000000, 16'h8001);
      add(MODE_SQUARE, 32'h00000000, 32'h12345678, 16'h7FFF);
      add(MODE_SAW,    32'h00000000, 32'h7FFF0000, 16'h7FFF);
      add(MODE_SAW,    32'h00000000, 32'h80000000, 16'h8000);
      add(MODE_SAW,    32'h00000000, 32'h12345678, 16'h1234);
      add(MODE_TRI,    32'h00000000, 32'h00000000, 16'h8000);
      add(MODE_TRI,    32'h00000000, 32'h80000000, 16'h7FFF);
      add(MODE_TRI,    32'h00000000, 32'h40000000, 16'h0000);
      add(MODE_TRI,    32'h00000000, 32'hC0000000, 16'hFFFF);

      tick(); tick();
      chk("rst_phase0", ph0, 32'h0);
      chk("rst_wrap0", {31'h0, wr0}, 32'h0);
      chk("rst_wave0", {16'h0, wv0}, 32'h0);
      chk("rst_valid0", {31'h0, ov0}, 32'h0);
      chk("rst_phase1", ph1, 32'h0);

      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         offset = vecs[i].offset;
         set_phase(vecs[i].ph);
         repeat (4) tick();
         chk($sformatf("vec%0d_wave", i), {16'h0, wv0}, {16'h0, vecs[i].exp});
      end

      mode = MODE_SINE; offset = '0;
      rst = 1'b1; tick(); rst = 1'b0;
      ctrl = 32'h01000000; ctrl_load = 1'b1; tick(); ctrl_load = 1'b0; tick();
      en = 1'b1;
      early_wrap = 1'b0;
      for (int k = 1; k <= 257; k++) begin
         tick();
         if (k < 256 && wr0) early_wrap = 1'b1;
         if (k == 1)   chk("run_ph1", ph0, 32'h01000000);
         if (k == 2)   chk("valid_k2", {31'h0, ov0}, 32'h0);
         if (k == 3)   chk("valid_k3", {31'h0, ov0}, 32'h1);
         if (k == 4)   chk("lat_sine_0324", {16'h0, wv0}, 32'h0324);
         if (k == 64)  chk("run_ph64", ph0, 32'h40000000);
         if (k == 67)  chk("lat_sine_7fff", {16'h0, wv0}, 32'h7FFF);
         if (k == 192) chk("run_ph192", ph0, 32'hC0000000);
         if (k == 195) chk("lat_sine_8001", {16'h0, wv0}, 32'h8001);
         if (k == 256) chk("wrap_phase", ph0, 32'h0);
         if (k == 256) chk("wrap_hi", {31'h0, wr0}, 32'h1);
         if (k == 257) chk("wrap_lo", {31'h0, wr0}, 32'h0);
      end
      chk("no_early_wrap", {31'h0, early_wrap}, 32'h0);
      en = 1'b0;

      rst = 1'b1; tick(); rst = 1'b0;
      ctrl = 32'h40000000; ctrl_load = 1'b1; tick();
      ctrl = 32'h11111111; phase_clr = 1'b1; tick();
      ctrl_load = 1'b0; phase_clr = 1'b0;
      chk("clr_phase1", ph1, 32'h0);
      en = 1'b1; tick();
      chk("sync_start", ph1, 32'h40000000);
      ctrl = 32'h20000000; ctrl_load = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         ctrl_load = 1'b0;
         chk($sformatf("sync_ph%0d", k), ph1, seq_ph[k]);
         chk($sformatf("sync_wrap%0d", k), {31'h0, wr1}, {31'h0, seq_wr[k]});
      end
      en = 1'b0;

      set_phase(32'h12345678);
      chk("pclr_pre", ph0, 32'h12345678);
      en = 1'b1; phase_clr = 1'b1; tick();
      phase_clr = 1'b0; en = 1'b0;
      chk("pclr_phase", ph0, 32'h0);
      chk("pclr_wrap", {31'h0, wr0}, 32'h0);

      mode = MODE_SINE;
      rst = 1'b1; tick(); rst = 1'b0;
      ctrl = 32'h01000000; ctrl_load = 1'b1; tick(); ctrl_load = 1'b0; tick();
      en = 1'b1;
      for (int k = 1; k <= 68; k++) begin
         tick();
         if (k == 64) mode = MODE_SAW;
         if (k == 66) chk("mode_last_sine", {16'h0, wv0}, 32'h7FF5);
         if (k == 67) chk("mode_first_saw", {16'h0, wv0}, 32'h4000);
         if (k == 68) chk("mode_second_saw", {16'h0, wv0}, 32'h4100);
      end
      mode = MODE_SINE;

      repeat (3) tick();
      ctrl = 32'h05000000; ctrl_load = 1'b1; tick();
      ctrl_load = 1'b0; rst = 1'b1; tick();
      chk("mid_rst_phase0", ph0, 32'h0);
      chk("mid_rst_wave0", {16'h0, wv0}, 32'h0);
      chk("mid_rst_valid0", {31'h0, ov0}, 32'h0);
      chk("mid_rst_wrap0", {31'h0, wr0}, 32'h0);
      chk("mid_rst_phase1", ph1, 32'h0);
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("post_rst_ph0_%0d", k), ph0, 32'h0);
         chk($sformatf("post_rst_ph1_%0d", k), ph1, 32'h0);
         if (k == 3) chk("post_rst_valid", {31'h0, ov0}, 32'h1);
      end
      en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nco_wave.md
NCO_WAVE -- requirements
Module: nco_wave

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator and control-word width.
REQ-002 SHALL have parameter OUT_W, default 16: signed output sample width.
REQ-003 SHALL have parameter LUT_AW, default 6: quarter-sine table address width, 2^LUT_AW entries.
REQ-004 SHALL have parameter SYNC_UPDATE, default 1: 1 applies a new control word at phase wrap, 0 applies it on the next cycle.
REQ-005 SHALL have ports: clk in 1, the single clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: en in 1, accumulator advance enable; ctrl in PHASE_W, frequency word; ctrl_load in 1, capture strobe for ctrl.
REQ-007 SHALL have ports: offset in PHASE_W, phase offset; mode in 2, waveform select (0 sine, 1 square, 2 saw, 3 triangle); phase_clr in 1, phase resync.
REQ-008 SHALL have ports: phase out PHASE_W, accumulator value; wrap out 1, carry pulse; wave_out out OUT_W, signed sample; out_valid out 1, sample qualifier.

Function
REQ-009 Accumulator SHALL update phase <= phase + ctrl_active mod 2^PHASE_W on each cycle with en=1, and hold when en=0.
REQ-010 wrap SHALL be 1 for exactly the cycle whose phase value resulted from a carry out of the add, and 0 otherwise.
REQ-011 ctrl_load SHALL copy ctrl into the pending register and set pend_flag; a second load before application SHALL overwrite pending.
REQ-012 With SYNC_UPDATE=0, ctrl_active SHALL take pending on the edge after ctrl_load.
REQ-013 With SYNC_UPDATE=1, ctrl_active SHALL take pending on the same edge that produces a carry, so the first post-wrap add uses the new word; pend_flag clears on that edge.
REQ-014 phase_clr SHALL force phase to 0 on the next edge, overriding en, raising no wrap, and applying any pending word immediately.
REQ-015 ctrl_load coincident with phase_clr or with a wrap edge SHALL be captured into pending and applied at the next qualifying event, not the current one.
REQ-016 The output pipeline SHALL have 3 registered stages advancing every cycle: S1 p = phase + offset mod 2^PHASE_W with mode; S2 table lookup or waveform compute; S3 sign and output. Latency SHALL be 3 cycles from phase to wave_out.
REQ-017 out_valid SHALL equal en delayed 3 cycles.
REQ-018 A mode change SHALL affect only samples entering S1 on or after the change; in-flight samples keep their own mode.
REQ-019 Sine: quadrant = p[MSB:MSB-1], idx = next LUT_AW bits. Quadrants 0/2 read idx; quadrants 1/3 read 2^LUT_AW - idx. In quadrants 1/3 with idx=0, output full scale instead of reading the table. Quadrants 2/3 SHALL be two's-complement negated.
REQ-020 Table entry k SHALL be round((2^(OUT_W-1)-1)*sin(pi*k/2^(LUT_AW+1))) for k = 0..2^LUT_AW-1. Full scale is 2^(OUT_W-1)-1, and sine never outputs -2^(OUT_W-1).
REQ-021 Square SHALL output +(2^(OUT_W-1)-1) when p MSB is 0, else -(2^(OUT_W-1)-1).
REQ-022 Saw SHALL output the top OUT_W bits of p read as signed, wrapping +max to -2^(OUT_W-1).
REQ-023 Triangle: u = p bits [PHASE_W-2 : PHASE_W-1-OUT_W]; v = MSB ? ~u : u; output SHALL be v with its top bit inverted, giving phase 0 -> -2^(OUT_W-1) and phase half -> 2^(OUT_W-1)-1.

Reset
REQ-024 rst SHALL clear on the next edge: phase, ctrl_active, pending, pend_flag, all pipeline stages, wave_out, out_valid and wrap; all outputs SHALL read 0.
REQ-025 rst SHALL take priority over en, ctrl_load and phase_clr, including mid-stream, and SHALL discard any pending word.

Structure
REQ-026 Package nco_pkg SHALL hold the mode encoding enum, the full-scale constant function of OUT_W, and the table-generation function.
REQ-027 The quarter table SHALL be sub-module nco_quarter_lut (params LUT_AW, OUT_W), registered as stage S2.

Verification
REQ-028 SYNC_UPDATE=0, sine, ctrl=0x01000000 loaded, en=1. Phases 0x01000000, 0x40000000 and 0xC0000000 SHALL give wave_out 0x0324, 0x7FFF and 0x8001 respectively, each 3 cycles later.
REQ-029 SYNC_UPDATE=1, active 0x40000000, ctrl_load=0x20000000 at phase 0x40000000. Phase SHALL run 0x80000000, 0xC0000000, 0x00000000 (wrap=1), 0x20000000, 0x40000000.
REQ-030 phase=0x12345678, en=1, phase_clr=1 for one cycle. The next phase SHALL be 0x00000000, with wrap=0.
REQ-031 Square, offset=0x80000000, phase 0 -> wave_out 0x8001. Triangle, offset 0: phase 0 -> 0x8000; phase 0x80000000 -> 0x7FFF.
REQ-032 Mode switched sine->saw mid-stream. Exactly 3 cycles later the first saw sample SHALL appear; earlier samples SHALL remain sine.
REQ-033 rst=1 mid-run with a pending word. The next cycle SHALL show phase=0, wave_out=0 and out_valid=0. After release with en=1 and no load, phase SHALL stay 0 (ctrl_active=0).
